// File: rtl/irq_arbiter.sv
// Interrupt arbiter: collects NCH level device requests into one CPU request line and
// runs the vector-fetch handshake. Define IRQ_ARBITER_RR_EN for round-robin priority.
module irq_arbiter #(
  parameter int NCH = 4
) (
  input  logic             clk_p,
  input  logic             rst_n,
  input  logic [NCH-1:0]   dev_req,
  input  logic [9*NCH-1:0] dev_vec,
  output logic [NCH-1:0]   dev_ack,
  output logic             irq_o,
  input  logic             istb_i,
  output logic [8:0]       ivec_o,
  output logic             iack_o
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, LATCH, ACK, DROP} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  sel;
  logic [IW-1:0]  win;
  logic [8:0]     vec;
  logic           take;
  logic [NCH-1:0] ack_vec;

`ifdef IRQ_ARBITER_RR_EN
  logic [IW-1:0] ptr;

  // First requester found when scanning upward from start, wrapping at NCH.
  function automatic logic [IW-1:0] pick(input logic [NCH-1:0] req,
                                         input logic [IW-1:0]  start);
    logic [IW-1:0] res;
    logic          found;
    int            idx;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(start) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && req[idx]) begin
        res   = IW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign win = pick(dev_req, ptr);
`else
  function automatic logic [IW-1:0] pick(input logic [NCH-1:0] req);
    logic [IW-1:0] res;
    res = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) res = IW'(i);
    end
    return res;
  endfunction

  assign win = pick(dev_req);
`endif

  assign take = (state == IDLE) && istb_i && (|dev_req);

  always_comb begin
    state_nxt = state;
    for (int i = 0; i < NCH; i++) ack_vec[i] = (sel == IW'(i));
    case (state)
      IDLE:    if (take) state_nxt = LATCH;
      LATCH:   state_nxt = ACK;
      ACK:     state_nxt = DROP;
      DROP:    if (!istb_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so each lags its state by one cycle
  // and the vector is on the bus a full cycle before iack_o.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      vec     <= '0;
      irq_o   <= 1'b0;
      iack_o  <= 1'b0;
      ivec_o  <= '0;
      dev_ack <= '0;
`ifdef IRQ_ARBITER_RR_EN
      ptr     <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (take) begin
        sel <= win;
        vec <= dev_vec[9*win +: 9];
      end
      irq_o   <= (state == IDLE) && !take && (|dev_req);
      ivec_o  <= (state != IDLE) ? vec : 9'd0;
      iack_o  <= (state == ACK) || (state == DROP);
      dev_ack <= (state == ACK) ? ack_vec : '0;
`ifdef IRQ_ARBITER_RR_EN
      if (state == ACK) ptr <= (sel == IW'(NCH - 1)) ? '0 : sel + 1'b1;
`endif
    end
  end

endmodule
